// File: rtl/adc_frame_pkg.sv
// Shared types and field positions for the ADC frame parser.
package adc_frame_pkg;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned STAT_W   = 16;
    localparam int unsigned GLBL_MSB = 63;
    localparam int unsigned GLBL_LSB = 32;
    localparam int unsigned ADC_MSB  = 31;
    localparam int unsigned ADC_LSB  = 0;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/axis_last_hold_buffer.sv
// One-word output hold buffer; tlast can be attached after the word is loaded.
module axis_last_hold_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop,
    input  logic             set_last,
    output logic             buf_valid,
    output logic [WIDTH-1:0] buf_data,
    output logic             buf_last
);

    // Load wins over pop (drain and refill in one cycle); set_last only tags a word that stays.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_last  <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_data  <= load_data;
            buf_last  <= 1'b0;
        end else if (pop) begin
            buf_valid <= 1'b0;
            buf_last  <= 1'b0;
        end else if (set_last && buf_valid) begin
            buf_last  <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_parser.sv
// Strips header/trailer from framed ADC beats, re-emits payload with tlast, checks counters.
module adc_frame_parser
    import adc_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned MAX_PAYLOAD_WORDS = 4096,
    parameter int unsigned CNT_OFFSET        = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  clear_stats,
    output logic [CNT_W-1:0]      hdr_glbl_cnt,
    output logic [CNT_W-1:0]      hdr_adc_cnt,
    output logic [CNT_W-1:0]      trl_glbl_cnt,
    output logic [CNT_W-1:0]      trl_adc_cnt,
    output logic [CNT_W-1:0]      payload_len,
    output logic                  frame_done,
    output logic                  err_runt,
    output logic                  err_count_mismatch,
    output logic                  err_overlength,
    output logic [STAT_W-1:0]     frame_count,
    output logic [STAT_W-1:0]     error_count
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pay_cnt;
    logic [CNT_W-1:0] exp_cnt_c;
    logic [CNT_W-1:0] len_c;
    logic             ready_c;
    logic             ovl_beat_c;
    logic             hdr_load_c;
    logic             trl_load_c;
    logic             buf_load_c;
    logic             close_buf_c;
    logic             done_c;
    logic             runt_c;
    logic             mism_c;
    logic             ovl_c;
    logic             buf_valid;
    logic             buf_last;
    logic             buf_pop_c;

    // Hold buffer between the input and the payload stream.
    axis_last_hold_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_hold (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (buf_load_c),
        .load_data (s_axis_tdata),
        .pop       (buf_pop_c),
        .set_last  (close_buf_c),
        .buf_valid (buf_valid),
        .buf_data  (m_axis_tdata),
        .buf_last  (buf_last)
    );

    assign buf_pop_c     = buf_valid && m_axis_tready;
    assign m_axis_tvalid = buf_valid;
    // Closing beat tags the buffered word combinationally so it can leave in the same cycle.
    assign m_axis_tlast  = buf_last || (buf_valid && close_buf_c);
    // Ready is forced low while reset is held so the source sees no acceptance.
    assign s_axis_tready = ready_c && aresetn;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, input ready and per-beat control decode.
    // Zero payload is judged by pay_cnt: the buffer may still hold the previous frame's last word.
    always_comb begin
        state_nxt   = state;
        ready_c     = 1'b0;
        hdr_load_c  = 1'b0;
        trl_load_c  = 1'b0;
        buf_load_c  = 1'b0;
        close_buf_c = 1'b0;
        done_c      = 1'b0;
        runt_c      = 1'b0;
        mism_c      = 1'b0;
        ovl_c       = 1'b0;
        len_c       = pay_cnt;
        ovl_beat_c  = s_axis_tvalid && !s_axis_tlast
                      && (pay_cnt == CNT_W'(MAX_PAYLOAD_WORDS));
        exp_cnt_c   = s_axis_tdata[ADC_MSB:ADC_LSB] - hdr_adc_cnt - CNT_W'(CNT_OFFSET);
        case (state)
            S_HDR: begin
                ready_c = 1'b1;
                len_c   = '0;
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        done_c = 1'b1;
                        runt_c = 1'b1;
                    end else begin
                        hdr_load_c = 1'b1;
                        state_nxt  = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    ready_c     = 1'b1;
                    trl_load_c  = 1'b1;
                    done_c      = 1'b1;
                    runt_c      = (pay_cnt == '0);
                    mism_c      = (pay_cnt != '0) && (exp_cnt_c != pay_cnt);
                    close_buf_c = (pay_cnt != '0);
                    state_nxt   = S_HDR;
                end else if (ovl_beat_c) begin
                    ready_c     = 1'b1;
                    done_c      = 1'b1;
                    ovl_c       = 1'b1;
                    close_buf_c = 1'b1;
                    state_nxt   = S_DROP;
                end else begin
                    ready_c    = !buf_valid || m_axis_tready;
                    buf_load_c = s_axis_tvalid && ready_c;
                end
            end
            S_DROP: begin
                ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt = S_HDR;
                end
            end
            default: begin
                state_nxt = S_HDR;
            end
        endcase
    end

    // Header/trailer capture, payload counting, frame status and statistics.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_glbl_cnt       <= '0;
            hdr_adc_cnt        <= '0;
            trl_glbl_cnt       <= '0;
            trl_adc_cnt        <= '0;
            pay_cnt            <= '0;
            payload_len        <= '0;
            frame_done         <= 1'b0;
            err_runt           <= 1'b0;
            err_count_mismatch <= 1'b0;
            err_overlength     <= 1'b0;
            frame_count        <= '0;
            error_count        <= '0;
        end else begin
            if (hdr_load_c) begin
                hdr_glbl_cnt <= s_axis_tdata[GLBL_MSB:GLBL_LSB];
                hdr_adc_cnt  <= s_axis_tdata[ADC_MSB:ADC_LSB];
                pay_cnt      <= '0;
            end else if (buf_load_c) begin
                pay_cnt <= pay_cnt + CNT_W'(1);
            end
            if (trl_load_c) begin
                trl_glbl_cnt <= s_axis_tdata[GLBL_MSB:GLBL_LSB];
                trl_adc_cnt  <= s_axis_tdata[ADC_MSB:ADC_LSB];
            end
            frame_done <= done_c;
            if (done_c) begin
                payload_len        <= len_c;
                err_runt           <= runt_c;
                err_count_mismatch <= mism_c;
                err_overlength     <= ovl_c;
            end
            if (clear_stats) begin
                frame_count <= '0;
                error_count <= '0;
            end else if (done_c) begin
                frame_count <= sat_inc(frame_count);
                if (runt_c || mism_c || ovl_c) begin
                    error_count <= sat_inc(error_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_parser.sv
// Directed bench for adc_frame_parser: clean, stalled, wrap, runt, over-length and reset frames.
module tb_adc_frame_parser;

    logic        aclk;
    logic        aresetn;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        clear_stats;
    logic [31:0] hdr_glbl_cnt;
    logic [31:0] hdr_adc_cnt;
    logic [31:0] trl_glbl_cnt;
    logic [31:0] trl_adc_cnt;
    logic [31:0] payload_len;
    logic        frame_done;
    logic        err_runt;
    logic        err_count_mismatch;
    logic        err_overlength;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    adc_frame_parser #(
        .DATA_WIDTH        (64),
        .MAX_PAYLOAD_WORDS (4),
        .CNT_OFFSET        (1)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tready      (m_axis_tready),
        .clear_stats        (clear_stats),
        .hdr_glbl_cnt       (hdr_glbl_cnt),
        .hdr_adc_cnt        (hdr_adc_cnt),
        .trl_glbl_cnt       (trl_glbl_cnt),
        .trl_adc_cnt        (trl_adc_cnt),
        .payload_len        (payload_len),
        .frame_done         (frame_done),
        .err_runt           (err_runt),
        .err_count_mismatch (err_count_mismatch),
        .err_overlength     (err_overlength),
        .frame_count        (frame_count),
        .error_count        (error_count)
    );

    initial aclk = 1'b0;
    always #2 aclk = ~aclk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          done_n  = 0;
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data = '0;
    logic [31:0] snap_len;
    logic        snap_runt;
    logic        snap_mism;
    logic        snap_ovl;
    logic [15:0] snap_fc;
    logic [15:0] snap_ec;
    logic [15:0] stall_mask;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: output beats, hold stability and frame_done snapshots.
    always @(negedge aclk) begin
        if (hold_pend && m_axis_tvalid)
            chk("hold_data", 65'(m_axis_tdata), 65'(hold_data));
        hold_pend = m_axis_tvalid && !m_axis_tready;
        hold_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tdata});
        if (frame_done) begin
            done_n++;
            snap_len  = payload_len;
            snap_runt = err_runt;
            snap_mism = err_count_mismatch;
            snap_ovl  = err_overlength;
            snap_fc   = frame_count;
            snap_ec   = error_count;
        end
    end

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat; returns just after the edge that accepted it, tvalid still high.
    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        @(negedge aclk);
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("s_tready", 65'(s_axis_tready), 65'(1));
        @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] hdr, input int n, input logic [63:0] base,
                              input logic [63:0] trl);
        send(hdr, 1'b0);
        for (int i = 0; i < n; i++) send(base + 64'(i), 1'b0);
        send(trl, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic build_exp(input int nout, input logic [63:0] base);
        exp_q.delete();
        for (int i = 0; i < nout; i++) exp_q.push_back({(i == nout - 1), base + 64'(i)});
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_n < target && n < 40) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_done_n"}, 65'(done_n), 65'(target));
    endtask

    task automatic check_beats(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 40) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        chk({tag, "_nbeats"}, 65'(got_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
    endtask

    task automatic check_frame(input string tag, input int len, input logic runt,
                               input logic mism, input logic ovl, input int fc, input int ec);
        chk({tag, "_len"},  65'(snap_len),  65'(len));
        chk({tag, "_runt"}, 65'(snap_runt), 65'(runt));
        chk({tag, "_mism"}, 65'(snap_mism), 65'(mism));
        chk({tag, "_ovl"},  65'(snap_ovl),  65'(ovl));
        chk({tag, "_fc"},   65'(snap_fc),   65'(fc));
        chk({tag, "_ec"},   65'(snap_ec),   65'(ec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        clear_stats   = 1'b0;
        stall_mask    = 16'h031C;
        repeat (2) @(negedge aclk);
        chk("rst_s_tready", 65'(s_axis_tready), 65'(0));
        chk("rst_m_tvalid", 65'(m_axis_tvalid), 65'(0));
        chk("rst_done",     65'(frame_done),    65'(0));
        chk("rst_fc",       65'(frame_count),   65'(0));
        chk("rst_len",      65'(payload_len),   65'(0));
        #1 aresetn = 1'b1;

        // Clean frame, full throughput.
        sync();
        build_exp(4, 64'hA0);
        send_frame({32'h10, 32'h0}, 4, 64'hA0, {32'h20, 32'h5});
        wait_done("t1", 1);
        check_beats("t1");
        check_frame("t1", 4, 0, 0, 0, 1, 0);
        chk("t1_hdr_glbl", 65'(hdr_glbl_cnt), 65'(32'h10));
        chk("t1_hdr_adc",  65'(hdr_adc_cnt),  65'(32'h0));
        chk("t1_trl_glbl", 65'(trl_glbl_cnt), 65'(32'h20));
        chk("t1_trl_adc",  65'(trl_adc_cnt),  65'(32'h5));

        // Same frame with downstream back-pressure, including during the trailer.
        sync();
        build_exp(4, 64'hB0);
        fork
            send_frame({32'h10, 32'h0}, 4, 64'hB0, {32'h20, 32'h5});
            begin
                for (int k = 0; k < 16; k++) begin
                    m_axis_tready = !stall_mask[k];
                    @(posedge aclk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_done("t2", 2);
        check_frame("t2", 4, 0, 0, 0, 2, 0);
        check_beats("t2");

        // Counter wrap: FFFF_FFFE -> 2 gives three payload words.
        sync();
        build_exp(3, 64'hC0);
        send_frame({32'h0, 32'hFFFF_FFFE}, 3, 64'hC0, {32'h0, 32'h2});
        wait_done("t3a", 3);
        check_frame("t3a", 3, 0, 0, 0, 3, 0);
        check_beats("t3a");

        sync();
        build_exp(3, 64'hC8);
        send_frame({32'h0, 32'hFFFF_FFFE}, 3, 64'hC8, {32'h0, 32'h3});
        wait_done("t3b", 4);
        check_frame("t3b", 3, 0, 1, 0, 4, 1);
        check_beats("t3b");

        // Header immediately followed by trailer.
        sync();
        build_exp(0, 64'h0);
        send_frame({32'h0, 32'h0}, 0, 64'h0, {32'h0, 32'h0});
        wait_done("t4a", 5);
        check_frame("t4a", 0, 1, 0, 0, 5, 2);
        check_beats("t4a");

        // Bare tlast beat with no header.
        sync();
        send({32'h77, 32'h77}, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_done("t4b", 6);
        check_frame("t4b", 0, 1, 0, 0, 6, 3);
        chk("t4b_trl_glbl", 65'(trl_glbl_cnt), 65'(32'h0));
        check_beats("t4b");

        // Over-length: six payload words against a limit of four.
        sync();
        build_exp(4, 64'hE0);
        send_frame({32'h0, 32'h0}, 6, 64'hE0, {32'h0, 32'h7});
        wait_done("t5", 7);
        check_frame("t5", 4, 0, 0, 1, 7, 4);
        check_beats("t5");
        chk("t5_single_done", 65'(done_n), 65'(7));

        sync();
        build_exp(4, 64'hF0);
        send_frame({32'h10, 32'h0}, 4, 64'hF0, {32'h20, 32'h5});
        wait_done("t5c", 8);
        check_frame("t5c", 4, 0, 0, 0, 8, 4);
        check_beats("t5c");

        // Reset with a word parked in the hold buffer.
        sync();
        m_axis_tready = 1'b0;
        send({32'h55, 32'h9}, 1'b0);
        send(64'h99, 1'b0);
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        chk("t6_full", 65'(m_axis_tvalid), 65'(1));
        #1 aresetn = 1'b0;
        #1;
        chk("t6_m_tvalid", 65'(m_axis_tvalid), 65'(0));
        chk("t6_m_tdata",  65'(m_axis_tdata),  65'(0));
        chk("t6_fc",       65'(frame_count),   65'(0));
        chk("t6_ec",       65'(error_count),   65'(0));
        chk("t6_len",      65'(payload_len),   65'(0));
        chk("t6_hdr_glbl", 65'(hdr_glbl_cnt),  65'(0));
        chk("t6_s_tready", 65'(s_axis_tready), 65'(0));
        @(negedge aclk);
        #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        got_q.delete();
        sync();
        build_exp(4, 64'h100);
        send_frame({32'h10, 32'h0}, 4, 64'h100, {32'h20, 32'h5});
        wait_done("t6c", 9);
        check_frame("t6c", 4, 0, 0, 0, 1, 0);
        check_beats("t6c");

        // Statistics clear.
        @(negedge aclk);
        #1 clear_stats = 1'b1;
        @(negedge aclk);
        #1 clear_stats = 1'b0;
        chk("clr_fc", 65'(frame_count), 65'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_frame_parser.md
Name: adc_frame_parser

Overview:
- Receive-side counterpart of the ADC capture framer. Sits on the aclk domain after the ADC AXI-stream output.
- Consumes 64-bit framed ADC beats laid out as: header word, payload words, trailer word. The trailer carries tlast.
- Strips the header and trailer and re-emits the payload as a clean AXI-stream, with tlast moved onto the last payload word.
- Publishes the header/trailer counters and per-frame integrity flags for the control/DMA logic.

Parameters:
DATA_WIDTH, 64, stream width; upper 32 bits = glbl_counter, lower 32 bits = adc_counter in header/trailer words
MAX_PAYLOAD_WORDS, 4096, payload length that triggers the over-length abort
CNT_OFFSET, 1, constant subtracted from (trailer adc_counter - header adc_counter) to get the expected payload word count

Ports:
aclk  in  1  stream clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  64  framed ADC data
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  marks the trailer word
s_axis_tready  out  1  input ready
m_axis_tdata  out  64  payload data
m_axis_tvalid  out  1  payload valid
m_axis_tlast  out  1  last payload word of the frame
m_axis_tready  in  1  downstream ready
clear_stats  in  1  synchronous clear of frame_count and error_count
hdr_glbl_cnt, hdr_adc_cnt  out  32 each  captured header fields
trl_glbl_cnt, trl_adc_cnt  out  32 each  captured trailer fields
payload_len  out  32  payload words in the last completed frame
frame_done  out  1  one-cycle pulse at the end of a frame; flags below are valid in the same cycle
err_runt, err_count_mismatch, err_overlength  out  1 each  status of the last frame
frame_count, error_count  out  16 each  saturating statistics

Behaviour:
- Reset: all outputs 0; state S_HDR; hold buffer empty. Reset asserted mid-frame discards the buffered word and the partial frame.
- States:
  - S_HDR: s_axis_tready=1.
    - Non-tlast beat: latch hdr_*, clear pay_cnt, go to S_PAY.
    - tlast beat: runt. frame_done=1, err_runt=1, stay in S_HDR.
  - S_PAY: payload beats go through a one-word hold buffer (buf_valid, buf_data, buf_last).
    - Non-tlast beat: s_axis_tready = !buf_valid || m_axis_tready. On accept: load the buffer, pay_cnt+1.
    - tlast beat (trailer): s_axis_tready=1. Latch trl_*.
      - If buf_valid and m_axis_tready: buffer word leaves this cycle with tlast=1.
      - If buf_valid and not m_axis_tready: set buf_last=1.
      - If !buf_valid (zero payload): err_runt=1, nothing emitted.
      - In all cases: frame_done pulses next cycle, go to S_HDR.
    - Over-length: a non-tlast beat arriving with pay_cnt==MAX_PAYLOAD_WORDS is dropped. The buffer is closed exactly as for a trailer, err_overlength=1, frame_done pulses, go to S_DROP.
  - S_DROP: s_axis_tready=1. Discard beats until a tlast beat is accepted, then go to S_HDR. No second frame_done.
- Output signals:
  - m_axis_tvalid = buf_valid.
  - m_axis_tlast = buf_last | (state==S_PAY & s_axis_tvalid & s_axis_tlast & buf_valid). This is a deliberate combinational path.
  - m_axis_tdata/tlast are held stable while tvalid is high and tready is low.
- Latency: one cycle from input accept to m_axis_tvalid. Full throughput when m_axis_tready=1.
- Header handling: a header may be accepted while the previous frame's last word is still buffered. The next payload beat stalls until that word drains.
- Count check, evaluated at the trailer: expected = (trl_adc_cnt - hdr_adc_cnt - CNT_OFFSET) mod 2^32, so wrap-around is legal. err_count_mismatch = (expected != pay_cnt). The check is skipped on runt and over-length frames.
- payload_len = pay_cnt at frame_done.
- Statistics:
  - frame_count increments on every frame_done.
  - error_count increments when any err flag is set. Both counters saturate at 16'hFFFF.
  - Error flags hold until the next frame_done.
  - clear_stats has priority over a simultaneous increment.

Decomposition:
- Package adc_frame_pkg holds:
  - state enum {S_HDR, S_PAY, S_DROP};
  - GLBL_MSB=63, GLBL_LSB=32, ADC_MSB=31, ADC_LSB=0;
  - the 32-bit counter width constant.
- One sub-module, axis_last_hold_buffer: the one-word buffer with load, pop, and set_last.

Test Plan:
- Header {32'h10,32'h0}, 4 payload words A..D, trailer {32'h20,32'h5}, m_axis_tready=1 → A..D out with tlast on D only; payload_len=4; no errors; frame_count=1.
- Same frame with m_axis_tready low on cycles 2-4 and during the trailer → data order preserved; D held with tlast=1 until ready; no beat lost or duplicated.
- Header adc 32'hFFFF_FFFE, 3 payload words, trailer adc 32'h2 → expected = 3, no mismatch (wrap case). Repeat with trailer adc 32'h3 → err_count_mismatch=1, error_count=1.
- Header immediately followed by trailer → err_runt=1, no m_axis beat. A bare tlast beat in S_HDR → err_runt=1.
- MAX_PAYLOAD_WORDS=4, 6 payload words, then trailer → 4 words out with tlast on the 4th, err_overlength=1, one frame_done; the next clean frame parses normally.
- aresetn pulsed low mid-payload with the buffer full → all outputs 0 immediately; the following clean frame parses correctly.
